// File: rtl/mynios2_cpu_oci_dct_packer_if.sv
// Handshake bundle between trace control, the DCT packer and the trace sink.
// The DUT side uses modport slave; the producer/sink side uses modport master.
interface mynios2_cpu_oci_dct_packer_if #(
  parameter int OVF_CNT_W = 8
);
  logic                 sym_valid;
  logic [1:0]           sym_data;
  logic                 sym_ready;
  logic                 flush;
  logic [29:0]          dct_buffer;
  logic [3:0]           dct_count;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [33:0]          frame_data;
  logic [OVF_CNT_W-1:0] ovf_count;

  modport slave (
    input  sym_valid, sym_data, flush, frame_ready,
    output sym_ready, dct_buffer, dct_count, frame_valid, frame_data, ovf_count
  );

  modport master (
    output sym_valid, sym_data, flush, frame_ready,
    input  sym_ready, dct_buffer, dct_count, frame_valid, frame_data, ovf_count
  );
endinterface

// File: rtl/mynios2_cpu_oci_dct_packer.sv
// Packs 2-bit DCT trace symbols into 30-bit frames behind a one-entry output register.
// Optional drop mode: define MYNIOS2_CPU_OCI_DCT_DROP_EN (sym_ready tied high, overflow counted).
module mynios2_cpu_oci_dct_packer #(
  parameter int MAX_SYMS  = 15,
  parameter int OVF_CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  mynios2_cpu_oci_dct_packer_if.slave   bus
);

  localparam logic [3:0] C_MAX = 4'(MAX_SYMS);

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;

  logic [29:0] r_buf;
  logic [3:0]  r_cnt;
  logic        r_fpend;
  logic        r_fv;
  logic [33:0] r_fd;

  logic        w_blocked;
  logic        w_full_hold;
  logic        w_sym_ready;
  logic        w_accept;
  logic [29:0] w_buf_acc;
  logic [3:0]  w_cnt_acc;
  logic        w_flush_req;
  logic        w_want;
  logic        w_emit;
  logic        w_carry;

  // Reset asserts immediately, releases two clk edges after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_blocked   = r_fv && !bus.frame_ready;
  assign w_full_hold = (r_cnt == C_MAX);

`ifdef MYNIOS2_CPU_OCI_DCT_DROP_EN
  assign w_sym_ready = 1'b1;
  // Pending-full frame leaving this cycle: the offered symbol starts the next frame.
  assign w_carry     = bus.sym_valid && w_full_hold && !w_blocked;
`else
  localparam logic [3:0] C_MAX_M1 = 4'(MAX_SYMS - 1);
  assign w_sym_ready = !((r_cnt == C_MAX_M1) && w_blocked) && !w_full_hold;
  assign w_carry     = 1'b0;
`endif

  assign w_accept    = bus.sym_valid && w_sym_ready && !w_full_hold;
  assign w_buf_acc   = w_accept ? {r_buf[27:0], bus.sym_data} : r_buf;
  assign w_cnt_acc   = r_cnt + {3'b000, w_accept};
  assign w_flush_req = bus.flush || r_fpend;
  assign w_want      = (w_cnt_acc == C_MAX) || (w_flush_req && (w_cnt_acc != 4'd0));
  assign w_emit      = w_want && !w_blocked;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (w_emit) begin
      r_buf <= w_carry ? {28'd0, bus.sym_data} : 30'd0;
      r_cnt <= w_carry ? 4'd1 : 4'd0;
    end else begin
      r_buf <= w_buf_acc;
      r_cnt <= w_cnt_acc;
    end
  end

  // A flush that cannot leave yet is remembered until its frame goes out.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)                                 r_fpend <= 1'b0;
    else if (w_emit)                              r_fpend <= 1'b0;
    else if (bus.flush && (w_cnt_acc != 4'd0))    r_fpend <= 1'b1;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_fv <= 1'b0;
      r_fd <= '0;
    end else if (w_emit) begin
      r_fv <= 1'b1;
      r_fd <= {w_cnt_acc, w_buf_acc};
    end else if (r_fv && bus.frame_ready) begin
      r_fv <= 1'b0;
    end
  end

`ifdef MYNIOS2_CPU_OCI_DCT_DROP_EN
  logic [OVF_CNT_W-1:0] r_ovf;
  logic                 w_drop;

  assign w_drop = bus.sym_valid && w_full_hold && w_blocked;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)                           r_ovf <= '0;
    else if (w_drop && (r_ovf != '1))       r_ovf <= r_ovf + 1'b1;
  end
  assign bus.ovf_count = r_ovf;
`else
  assign bus.ovf_count = '0;
`endif

  assign bus.sym_ready   = w_sym_ready;
  assign bus.dct_buffer  = r_buf;
  assign bus.dct_count   = r_cnt;
  assign bus.frame_valid = r_fv;
  assign bus.frame_data  = r_fd;

endmodule
